// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length/word/XOR-checksum byte stream and
// writes the words into program RAM port 0 from address 0, then releases the core.
module prog_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              ram_write_en0_o,
  output logic [ADDR_W-1:0] ram_addr0_o,
  output logic [15:0]       ram_din0_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              start_o,
  output logic [7:0]        words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [7:0]          xor_q, xor_d;
  logic [7:0]          words_q, words_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         din_q, din_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                start_q, start_d;

  logic                accept;
  logic [15:0]         n_len;
  logic [ADDR_W:0]     idx_inc;

  assign accept  = rx_valid_i && rdy_q;
  assign n_len   = {hi_q, rx_data_i};
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    len_d   = len_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = done_q;
    err_d   = err_q;
    start_d = start_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_req_i) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          start_d = 1'b0;
          words_d = '0;
          xor_d   = '0;
          idx_d   = '0;
        end
      end
      S_LEN_HI: if (accept) begin
        hi_d    = rx_data_i;
        xor_d   = xor_q ^ rx_data_i;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        xor_d = xor_q ^ rx_data_i;
        if (n_len == 16'd0 || n_len > 16'(DEPTH)) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          len_d   = n_len[ADDR_W:0];
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) begin
        hi_d    = rx_data_i;
        xor_d   = xor_q ^ rx_data_i;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (accept) begin
        xor_d   = xor_q ^ rx_data_i;
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        din_d   = {hi_q, rx_data_i};
        idx_d   = idx_inc;
        words_d = words_q + 8'd1;
        // idx is one bit wider than the address so N=DEPTH terminates without wrap
        state_d = (idx_inc == len_q) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: if (accept) begin
        if (rx_data_i == xor_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          start_d = 1'b1;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA_HI) ||
             (state_d == S_DATA_LO) || (state_d == S_CHECK);
    busy_d = rdy_d || we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      words_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      words_q <= words_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign rx_ready_o      = rdy_q;
  assign ram_write_en0_o = we_q;
  assign ram_addr0_o     = addr_q;
  assign ram_din0_o      = din_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign start_o         = start_q;
  assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad loads, length bounds, stalls, reset mid-load.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_req = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready, we, busy, done, err, start;
  logic [6:0] addr;
  logic [15:0] din;
  logic [7:0] words;

  prog_loader #(.ADDR_W(7), .DEPTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .load_req_i(load_req), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .rx_ready_o(rx_ready), .ram_write_en0_o(we),
    .ram_addr0_o(addr), .ram_din0_o(din), .busy_o(busy), .done_o(done),
    .err_o(err), .start_o(start), .words_loaded_o(words)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] mem [0:127];
  int  wcount = 0;
  bit  dbl = 1'b0;
  logic prev_we = 1'b0;

  // RAM model: captures every strobe and flags strobes lasting more than one cycle
  always @(negedge clk) begin
    if (rst_n && we) begin
      mem[addr] = din;
      wcount++;
      if (prev_we) dbl = 1'b1;
    end
    prev_we = we;
  end

  logic [7:0]  good_s [9] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h42};
  logic [15:0] good_w [3] = '{16'h1234, 16'hABCD, 16'h0001};

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int t;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin
        if (poke) load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!rx_ready) begin
      failures++;
      $display("FAIL rx_ready_timeout byte=%h got=0 want=1", b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    for (int i = 0; i < 128; i++) mem[i] = 16'hDEAD;
    wcount = 0;
    dbl = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL req_ready got=%b%b want=11", rx_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      load_req = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      checks++;
      if ({rx_ready, we, addr, din, busy, done, err, start, words} !== 37'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%h want=0", {rx_ready, we, addr, din, busy, done, err, start, words});
      end
    end
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_not_ready got=%b%b want=00", rx_ready, busy);
      end
    end
  endtask

  task automatic test_good();
    start_load();
    send_byte(good_s[0], 0, 1'b0);
    send_byte(good_s[1], 0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      send_byte(good_s[2 + 2*w], 0, 1'b0);
      checks++;
      if (we !== 1'b0) begin
        failures++;
        $display("FAIL strobe_after_hi w=%0d got=%b want=0", w, we);
      end
      send_byte(good_s[3 + 2*w], 0, 1'b0);
      checks++;
      if (we !== 1'b1 || addr !== 7'(w) || din !== good_w[w] || busy !== 1'b1) begin
        failures++;
        $display("FAIL write w=%0d got we=%b a=%0d d=%h busy=%b want 1 %0d %h 1",
                 w, we, addr, din, busy, w, good_w[w]);
      end
    end
    send_byte(good_s[8], 0, 1'b0);
    rx_valid = 1'b0;
    checks++;
    if ({done, start, err, busy, rx_ready, we} !== 6'b110000 || words !== 8'd3) begin
      failures++;
      $display("FAIL good_done got=%b words=%0d want=110000 words=3",
               {done, start, err, busy, rx_ready, we}, words);
    end
    checks++;
    if (wcount !== 3 || dbl || mem[0] !== 16'h1234 || mem[1] !== 16'hABCD || mem[2] !== 16'h0001) begin
      failures++;
      $display("FAIL good_ram got n=%0d dbl=%b %h %h %h want 3 0 1234 abcd 0001",
               wcount, dbl, mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_bad_csum();
    start_load();
    checks++;
    if (start !== 1'b0 || done !== 1'b0 || words !== 8'd0) begin
      failures++;
      $display("FAIL start_clear got start=%b done=%b words=%0d want 0 0 0", start, done, words);
    end
    for (int i = 0; i < 8; i++) send_byte(good_s[i], 0, 1'b0);
    send_byte(8'h43, 0, 1'b0);
    rx_valid = 1'b0;
    checks++;
    if ({err, start, done, busy} !== 4'b1000 || wcount !== 3 || words !== 8'd3) begin
      failures++;
      $display("FAIL bad_csum got esdb=%b n=%0d words=%0d want 1000 3 3",
               {err, start, done, busy}, wcount, words);
    end
  endtask

  task automatic test_len_bounds();
    logic [7:0] lo_v [2] = '{8'h00, 8'h81};
    logic [7:0] x;
    int bad;
    for (int k = 0; k < 2; k++) begin
      start_load();
      send_byte(8'h00, 0, 1'b0);
      send_byte(lo_v[k], 0, 1'b0);
      rx_valid = 1'b0;
      checks++;
      if ({err, done, start, rx_ready, busy} !== 5'b10000 || wcount !== 0) begin
        failures++;
        $display("FAIL len_err lo=%h got=%b n=%0d want=10000 0", lo_v[k], {err, done, start, rx_ready, busy}, wcount);
      end
    end
    start_load();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h80, 0, 1'b0);
    x = 8'h80;
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i) ^ 8'h5A, 0, 1'b0);
      send_byte(8'(i), 0, 1'b0);
      x = x ^ 8'(i) ^ 8'h5A ^ 8'(i);
    end
    send_byte(x, 0, 1'b0);
    rx_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== {8'(i) ^ 8'h5A, 8'(i)}) bad++;
    checks++;
    if (bad != 0 || wcount !== 128 || dbl) begin
      failures++;
      $display("FAIL full_ram got bad=%0d n=%0d dbl=%b want 0 128 0", bad, wcount, dbl);
    end
    checks++;
    if ({done, start, err} !== 3'b110 || words !== 8'd128) begin
      failures++;
      $display("FAIL full_done got=%b words=%0d want=110 128", {done, start, err}, words);
    end
  endtask

  task automatic test_stalls();
    start_load();
    for (int i = 0; i < 9; i++) send_byte(good_s[i], int'($urandom_range(0, 3)), 1'b1);
    rx_valid = 1'b0;
    checks++;
    if ({done, start, err} !== 3'b110 || words !== 8'd3 || wcount !== 3 || dbl ||
        mem[0] !== 16'h1234 || mem[1] !== 16'hABCD || mem[2] !== 16'h0001) begin
      failures++;
      $display("FAIL stall_load got dse=%b words=%0d n=%0d %h %h %h want 110 3 3 1234 abcd 0001",
               {done, start, err}, words, wcount, mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_reset_mid();
    start_load();
    for (int i = 0; i < 5; i++) send_byte(good_s[i], 0, 1'b0);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    checks++;
    if ({rx_ready, we, addr, din, busy, done, err, start, words} !== 37'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", {rx_ready, we, addr, din, busy, done, err, start, words});
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_good();
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_len_bounds();
    test_stalls();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the processor's 2-port 16x128 program RAM. Accepts a byte stream (length header, 16-bit words high byte first, XOR checksum), writes the words into program RAM port 0 from address 0, then raises `start` to release the processor. While `busy` is high, top-level logic routes RAM port 0 address, write enable and write data from this block instead of from the processor `pc`.

## Interface
- `ADDR_W`, 7, program RAM address width.
- `DEPTH`, 128, maximum word count; must equal 2^ADDR_W.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_req`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- `rx_valid`  in  1  byte-stream valid.
- `rx_data`  in  8  byte-stream data.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on an edge where `rx_valid && rx_ready`.
- `ram_write_en0`  out  1  program RAM port 0 write strobe.
- `ram_addr0`  out  ADDR_W  program RAM port 0 address.
- `ram_din0`  out  16  program RAM port 0 write data.
- `busy`  out  1  load in progress; selects loader onto RAM port 0.
- `done`  out  1  last load completed with a good checksum.
- `err`  out  1  last load failed (bad length or checksum).
- `start`  out  1  processor start level.
- `words_loaded`  out  8  words written during the current or last load.

## Operation
- Stream format: LEN_HI, LEN_LO (N = {LEN_HI, LEN_LO}), then N words sent as HI byte then LO byte, then one checksum byte equal to the XOR of every preceding byte, including both length bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + `load_req` -> LEN_HI. Clear `done`, `err`, `start`, `words_loaded`, the running XOR and the word index.
- `load_req` in any other state is ignored.
- LEN_HI -> LEN_LO on accept.
- LEN_LO on accept: N==0 or N>DEPTH -> ERROR; otherwise -> DATA_HI.
- DATA_HI on accept: latch the high byte -> DATA_LO.
- DATA_LO on accept: issue one write with addr = word index and data = {hi, lo}. Increment the index and `words_loaded`. If this was word N -> CHECK, else -> DATA_HI.
- CHECK on accept: received byte == running XOR -> DONE, else -> ERROR.
- DONE: `done`=1, `start`=1, held until the next `load_req` or reset.
- ERROR: `err`=1, `start`=0, held likewise. Words already written remain in RAM.
- `rx_ready`=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
- `busy`=1 in those same states, and also in the cycle the final write strobe is active.
- Word index is ADDR_W+1 bits wide. N=DEPTH writes addresses 0..DEPTH-1 with no wrap.
- `words_loaded` saturates at N; it never exceeds DEPTH.

## Timing
- Reset values (asserted asynchronously on `rst_n` low): state IDLE, and every output 0. This includes `rx_ready`, `ram_write_en0`, `ram_addr0`, `ram_din0` and `start`.
- Reset mid-load returns the block to IDLE immediately. A partially written RAM image is not cleared.
- All outputs are registered.
- `rx_ready` reflects the current state. It rises the cycle after `load_req` is sampled.
- Write latency: a LO byte accepted on edge k gives `ram_write_en0`=1 with valid `ram_addr0`/`ram_din0` during cycle k..k+1, for exactly one cycle.
- Throughput: with `rx_valid` held high, one byte per cycle. A full load takes 2N+3 accepted bytes.
- `done`/`start` (or `err`) rise on the edge after the checksum byte is accepted. `busy` falls on that same edge.
- `start` falls on the edge after a new `load_req` is sampled in DONE.
- Stalls (`rx_valid`=0) hold all state. No timeout.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs 0; after release `rx_ready`=0 until `load_req`.
- Good load, back-to-back bytes:
  - Stimulus: 00 03 12 34 AB CD 00 01 42.
  - Writes: addr 0=0x1234, 1=0xABCD, 2=0x0001, each a one-cycle strobe.
  - Completion: `done`=`start`=1 one cycle after byte 42; `words_loaded`=3; `err`=0.
- Bad checksum: same stream ending in 43 -> three writes still occur; `err`=1, `start`=0, `done`=0.
- Length bounds:
  - 00 00 -> ERROR after LEN_LO with no writes.
  - 00 81 -> ERROR.
  - 00 80 + 256 data bytes + correct XOR -> addresses 0..127 written, `done`=1.
- Stalls and ignored requests: good load with random `rx_valid` gaps and `load_req` pulses while `busy` -> identical writes and result.
- Reset mid-load: `rst_n` low while in DATA_LO of word 1 -> outputs 0 asynchronously. A subsequent good load completes with `done`=1.
